// File: rtl/pipelined_source_fetching_unit.sv
// Operand fetch stage: decodes per-operand source fields, reads the register
// file (with same-cycle write-back forwarding) and input channels, and holds
// the fetched operands in a single output slot behind a valid/ready handshake.
module pipelined_source_fetching_unit #(
    parameter int NUM_OPERANDS       = 3,
    parameter int WORD_WIDTH         = 32,
    parameter int IMMEDIATE_WIDTH    = 32,
    parameter int NUM_INPUT_CHANNELS = 4,
    parameter int SINGLE_ST_WIDTH    = 2,
    parameter int SINGLE_SI_WIDTH    = 3,
    parameter int STALL_COUNT_WIDTH  = 16
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [NUM_OPERANDS*SINGLE_ST_WIDTH-1:0]  st,
    input  logic [NUM_OPERANDS*SINGLE_SI_WIDTH-1:0]  si,
    input  logic [IMMEDIATE_WIDTH-1:0]               immediate,
    input  logic [NUM_INPUT_CHANNELS*WORD_WIDTH-1:0] input_channel_data,
    input  logic [NUM_INPUT_CHANNELS-1:0]            input_channel_empty,
    output logic [NUM_INPUT_CHANNELS-1:0]            input_channel_dequeue,
    output logic [NUM_OPERANDS*SINGLE_SI_WIDTH-1:0]  register_read_index,
    input  logic [NUM_OPERANDS*WORD_WIDTH-1:0]       register_read_data,
    input  logic                                     register_write_enable,
    input  logic [SINGLE_SI_WIDTH-1:0]               register_write_index,
    input  logic [WORD_WIDTH-1:0]                    register_write_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [NUM_OPERANDS*WORD_WIDTH-1:0]       operands,
    output logic [STALL_COUNT_WIDTH-1:0]             stall_count
);

    localparam logic [SINGLE_ST_WIDTH-1:0] ST_IMMEDIATE = SINGLE_ST_WIDTH'(1);
    localparam logic [SINGLE_ST_WIDTH-1:0] ST_CHANNEL   = SINGLE_ST_WIDTH'(2);
    localparam logic [SINGLE_ST_WIDTH-1:0] ST_REGISTER  = SINGLE_ST_WIDTH'(3);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                                state_q, state_d;
    logic [NUM_OPERANDS*WORD_WIDTH-1:0]    operands_q, operands_d;
    logic [STALL_COUNT_WIDTH-1:0]          stall_count_q, stall_count_d;

    logic [NUM_OPERANDS*WORD_WIDTH-1:0]    fetched;
    logic [NUM_INPUT_CHANNELS-1:0]         chan_ref;
    logic                                  channel_ok;
    logic                                  accept;

    function automatic logic [WORD_WIDTH-1:0] sign_extend(input logic [IMMEDIATE_WIDTH-1:0] imm);
        logic [WORD_WIDTH-1:0] w;
        w = {WORD_WIDTH{imm[IMMEDIATE_WIDTH-1]}};
        w[IMMEDIATE_WIDTH-1:0] = imm;
        return w;
    endfunction

    // Decode each operand slot into its value, register address and channel use.
    // Out-of-range channel indices match no channel, so they yield 0 and never block.
    always_comb begin : decode
        logic [SINGLE_ST_WIDTH-1:0] st_k;
        logic [SINGLE_SI_WIDTH-1:0] si_k;
        fetched             = '0;
        register_read_index = '0;
        chan_ref            = '0;
        for (int k = 0; k < NUM_OPERANDS; k++) begin
            st_k = st[k*SINGLE_ST_WIDTH +: SINGLE_ST_WIDTH];
            si_k = si[k*SINGLE_SI_WIDTH +: SINGLE_SI_WIDTH];
            case (st_k)
                ST_IMMEDIATE: begin
                    fetched[k*WORD_WIDTH +: WORD_WIDTH] = sign_extend(immediate);
                end
                ST_CHANNEL: begin
                    for (int c = 0; c < NUM_INPUT_CHANNELS; c++) begin
                        if (si_k == SINGLE_SI_WIDTH'(c)) begin
                            fetched[k*WORD_WIDTH +: WORD_WIDTH] = input_channel_data[c*WORD_WIDTH +: WORD_WIDTH];
                            chan_ref[c] = 1'b1;
                        end
                    end
                end
                ST_REGISTER: begin
                    register_read_index[k*SINGLE_SI_WIDTH +: SINGLE_SI_WIDTH] = si_k;
                    if (register_write_enable && register_write_index == si_k) begin
                        fetched[k*WORD_WIDTH +: WORD_WIDTH] = register_write_data;
                    end else begin
                        fetched[k*WORD_WIDTH +: WORD_WIDTH] = register_read_data[k*WORD_WIDTH +: WORD_WIDTH];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign channel_ok            = ~|(chan_ref & input_channel_empty);
    assign in_ready              = channel_ok && (state_q == S_EMPTY || out_ready);
    assign accept                = in_valid && in_ready;
    assign input_channel_dequeue = (accept && !reset) ? chan_ref : '0;
    assign out_valid             = (state_q == S_FULL);
    assign operands              = operands_q;
    assign stall_count           = stall_count_q;

    // Output-slot FSM, operand capture and channel-stall counting.
    always_comb begin
        state_d       = state_q;
        operands_d    = operands_q;
        stall_count_d = stall_count_q;
        if (accept) begin
            state_d    = S_FULL;
            operands_d = fetched;
        end else if (state_q == S_FULL && out_ready) begin
            state_d = S_EMPTY;
        end
        // Only count stalls that the channels alone are responsible for.
        if (in_valid && !channel_ok && (state_q == S_EMPTY || out_ready) &&
            stall_count_q != {STALL_COUNT_WIDTH{1'b1}}) begin
            stall_count_d = stall_count_q + STALL_COUNT_WIDTH'(1);
        end
    end

    // State, operand and counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_EMPTY;
            operands_q    <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            operands_q    <= operands_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_pipelined_source_fetching_unit.sv
// Bench for pipelined_source_fetching_unit with default parameters.
module tb_pipelined_source_fetching_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  st;
    logic [8:0]  si;
    logic [31:0] immediate;
    logic [127:0] input_channel_data;
    logic [3:0]  input_channel_empty;
    logic [3:0]  input_channel_dequeue;
    logic [8:0]  register_read_index;
    logic [95:0] register_read_data;
    logic        register_write_enable;
    logic [2:0]  register_write_index;
    logic [31:0] register_write_data;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] operands;
    logic [15:0] stall_count;

    pipelined_source_fetching_unit #(
        .NUM_OPERANDS(3), .WORD_WIDTH(32), .IMMEDIATE_WIDTH(32),
        .NUM_INPUT_CHANNELS(4), .SINGLE_ST_WIDTH(2), .SINGLE_SI_WIDTH(3),
        .STALL_COUNT_WIDTH(16)
    ) dut (
        .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .st(st), .si(si), .immediate(immediate),
        .input_channel_data(input_channel_data),
        .input_channel_empty(input_channel_empty),
        .input_channel_dequeue(input_channel_dequeue),
        .register_read_index(register_read_index),
        .register_read_data(register_read_data),
        .register_write_enable(register_write_enable),
        .register_write_index(register_write_index),
        .register_write_data(register_write_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .operands(operands), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file and channel heads.
    logic [31:0] rf [8];
    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 32'hA000_0000 + i;
        rf[2] = 32'h0000_1234;
        rf[5] = 32'h0000_1111;
    end
    assign input_channel_data = {32'h0000_00CD, 32'h0000_0055, 32'h0000_00AB, 32'h0000_0010};

    always_comb begin
        register_read_data = '0;
        for (int k = 0; k < 3; k++)
            register_read_data[k*32 +: 32] = rf[register_read_index[k*3 +: 3]];
    end

    typedef struct {
        logic [5:0]  st;
        logic [8:0]  si;
        logic [31:0] imm;
        logic        we;
        logic [2:0]  widx;
        logic [31:0] wdata;
        logic [3:0]  empty;
        logic [95:0] ops;
        logic [3:0]  deq;
        logic [8:0]  rdidx;
    } vec_t;

    vec_t vecs [7];
    logic [95:0] exp_q [$];
    logic [95:0] mon_exp;
    int n_total = 0;
    int n_pass  = 0;
    int exp_stall = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        in_valid              = 1'b1;
        st                    = v.st;
        si                    = v.si;
        immediate             = v.imm;
        register_write_enable = v.we;
        register_write_index  = v.widx;
        register_write_data   = v.wdata;
        input_channel_empty   = v.empty;
    endtask

    // Drive one instruction after the next edge and expect it to be accepted.
    task automatic issue(input vec_t v, input string name);
        @(posedge clk); #1;
        drive(v);
        @(negedge clk);
        chk({name, "_in_ready"}, 128'(in_ready), 128'(1'b1));
        chk({name, "_dequeue"}, 128'(input_channel_dequeue), 128'(v.deq));
        chk({name, "_rd_index"}, 128'(register_read_index), 128'(v.rdidx));
        exp_q.push_back(v.ops);
    endtask

    // Output side: compare operands on each completed output handshake.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("out_unexpected", 128'(operands), 128'hX);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("out_operands", 128'(operands), 128'(mon_exp));
            end
        end
    end

    vec_t va, vb, vx;

    initial begin
        //                st                 si                 imm            we  widx  wdata          empty    ops                                              deq      rdidx
        vecs[0] = '{{2'd3,2'd0,2'd1}, {3'd2,3'd0,3'd0}, 32'hFFFF_FFFE, 1'b0, 3'd0, 32'h0,         4'h0, {32'h0000_1234,32'h0,32'hFFFF_FFFE},             4'b0000, {3'd2,3'd0,3'd0}};
        vecs[1] = '{{2'd2,2'd2,2'd2}, {3'd3,3'd1,3'd1}, 32'h0,         1'b0, 3'd0, 32'h0,         4'h0, {32'h0000_00CD,32'h0000_00AB,32'h0000_00AB},     4'b1010, 9'd0};
        vecs[2] = '{{2'd3,2'd2,2'd2}, {3'd1,3'd0,3'd7}, 32'h0,         1'b0, 3'd0, 32'h0,         4'h0, {32'hA000_0001,32'h0000_0010,32'h0},             4'b0001, {3'd1,3'd0,3'd0}};
        vecs[3] = '{{2'd3,2'd3,2'd3}, {3'd7,3'd3,3'd0}, 32'h0,         1'b0, 3'd0, 32'h0,         4'h0, {32'hA000_0007,32'hA000_0003,32'hA000_0000},     4'b0000, {3'd7,3'd3,3'd0}};
        vecs[4] = '{{2'd0,2'd2,2'd1}, {3'd0,3'd2,3'd0}, 32'h7FFF_FFFF, 1'b0, 3'd0, 32'h0,         4'h0, {32'h0,32'h0000_0055,32'h7FFF_FFFF},             4'b0100, 9'd0};
        vecs[5] = '{{2'd0,2'd3,2'd3}, {3'd0,3'd4,3'd5}, 32'h0,         1'b1, 3'd5, 32'h0000_2222, 4'h0, {32'h0,32'hA000_0004,32'h0000_2222},             4'b0000, {3'd0,3'd4,3'd5}};
        vecs[6] = '{{2'd0,2'd0,2'd2}, {3'd0,3'd0,3'd7}, 32'h0,         1'b0, 3'd0, 32'h0,         4'hF, 96'h0,                                           4'b0000, 9'd0};

        va = '{{2'd0,2'd0,2'd3}, {3'd0,3'd0,3'd1}, 32'h0,         1'b0, 3'd0, 32'h0, 4'h0, {32'h0,32'h0,32'hA000_0001}, 4'b0000, {3'd0,3'd0,3'd1}};
        vb = '{{2'd0,2'd0,2'd2}, {3'd0,3'd0,3'd0}, 32'h0,         1'b0, 3'd0, 32'h0, 4'h0, {32'h0,32'h0,32'h0000_0010}, 4'b0001, 9'd0};
        vx = '{{2'd0,2'd0,2'd1}, {3'd0,3'd0,3'd0}, 32'h5A5A_5A5A, 1'b0, 3'd0, 32'h0, 4'h0, {32'h0,32'h0,32'h5A5A_5A5A}, 4'b0000, 9'd0};

        reset = 1'b1; in_valid = 1'b0; st = '0; si = '0; immediate = '0;
        input_channel_empty = '0; register_write_enable = 1'b0;
        register_write_index = '0; register_write_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_operands", 128'(operands), 128'h0);
        chk("rst_stall", 128'(stall_count), 128'h0);
        chk("rst_dequeue", 128'(input_channel_dequeue), 128'h0);
        chk("rst_in_ready", 128'(in_ready), 128'(1'b1));

        // Back-to-back table vectors.
        for (int i = 0; i < 7; i++) issue(vecs[i], $sformatf("vec%0d", i));

        // Channel 2 empty for five cycles, then filled.
        @(posedge clk); #1;
        drive(vecs[4]);
        st = {2'd0,2'd0,2'd2}; si = {3'd0,3'd0,3'd2}; input_channel_empty = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_in_ready", i), 128'(in_ready), 128'(1'b0));
            chk($sformatf("stall%0d_dequeue", i), 128'(input_channel_dequeue), 128'h0);
            @(posedge clk); #1;
        end
        input_channel_empty = 4'b0000;
        exp_stall = 5;
        @(negedge clk);
        chk("stall_count", 128'(stall_count), 128'(16'(exp_stall)));
        chk("fill_in_ready", 128'(in_ready), 128'(1'b1));
        chk("fill_dequeue", 128'(input_channel_dequeue), 128'(4'b0100));
        exp_q.push_back({32'h0, 32'h0, 32'h0000_0055});

        // Backpressure with a new instruction waiting.
        issue(va, "bp_a");
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(vb);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_in_ready", i), 128'(in_ready), 128'(1'b0));
            chk($sformatf("bp%0d_dequeue", i), 128'(input_channel_dequeue), 128'h0);
            chk($sformatf("bp%0d_out_valid", i), 128'(out_valid), 128'(1'b1));
            chk($sformatf("bp%0d_operands", i), 128'(operands), 128'(va.ops));
            chk($sformatf("bp%0d_stall", i), 128'(stall_count), 128'(16'(exp_stall)));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 128'(in_ready), 128'(1'b1));
        chk("bp_release_dequeue", 128'(input_channel_dequeue), 128'(4'b0001));
        exp_q.push_back(vb.ops);

        // Drain, then reset while FULL.
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive(vx);
        @(negedge clk);
        chk("rstfull_accept", 128'(in_ready), 128'(1'b1));
        @(posedge clk); #1;
        reset = 1'b1;
        out_ready = 1'b1;
        drive(vb);
        @(negedge clk);
        chk("rstfull_out_valid", 128'(out_valid), 128'(1'b1));
        chk("rstfull_operands", 128'(operands), 128'(vx.ops));
        chk("rstfull_no_dequeue", 128'(input_channel_dequeue), 128'h0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("after_rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("after_rst_operands", 128'(operands), 128'h0);
        chk("after_rst_stall", 128'(stall_count), 128'h0);
        chk("after_rst_dequeue", 128'(input_channel_dequeue), 128'h0);

        repeat (2) @(negedge clk);
        chk("queue_drained", 128'(exp_q.size()), 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
